// File: rtl/line_unpack_buffer_if.sv
// Purpose: bundles the line-in / element-out handshakes of line_unpack_buffer.
// Latency: none; wires only.
// Backpressure: in_ready toward the line source, out_ready from the element consumer.
// Ports: in_* carries a line with its [base, bounds) window and last flag; out_* carries
//        one element; drain_done marks end of stream; lines reports buffer occupancy.
interface line_unpack_buffer_if #(
  parameter int FULL_WIDTH = 512,
  parameter int WIDTH      = 64,
  parameter int LOG_DEPTH  = 4
);
  logic                  in_valid;
  logic                  in_ready;
  logic [FULL_WIDTH-1:0] in_data;
  logic [7:0]            in_base;
  logic [7:0]            in_bounds;
  logic                  in_last;
  logic                  out_valid;
  logic                  out_ready;
  logic [WIDTH-1:0]      out_data;
  logic                  out_last;
  logic                  drain_done;
  logic [LOG_DEPTH:0]    lines;

  // Buffer side.
  modport slave (
    input  in_valid, in_data, in_base, in_bounds, in_last, out_ready,
    output in_ready, out_valid, out_data, out_last, drain_done, lines
  );

  // Producer/consumer side.
  modport master (
    output in_valid, in_data, in_base, in_bounds, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_last, drain_done, lines
  );
endinterface

// File: rtl/line_unpack_buffer.sv
// Purpose: buffers 2^LOG_DEPTH wide lines and streams each line's [base, eb) window as elements.
// Latency: first element visible the cycle after a line is accepted into an empty buffer.
// Backpressure: in_ready drops only when full (independent of out_ready); out side holds on !out_ready.
// Ports: clk, rst (sync, active-high); bus (slave modport) carries in_* line handshake,
//        out_* element handshake, drain_done pulse and lines occupancy count.
module line_unpack_buffer #(
  parameter int FULL_WIDTH = 512,
  parameter int WIDTH      = 64,
  parameter int LOG_DEPTH  = 4
) (
  input  logic                clk,
  input  logic                rst,
  line_unpack_buffer_if.slave bus
);
  localparam int                   MAX_ELEMS = FULL_WIDTH / WIDTH;
  localparam int                   DEPTH     = 1 << LOG_DEPTH;
  localparam logic [7:0]           MAX_EB    = 8'(MAX_ELEMS);
  localparam logic [LOG_DEPTH:0]   FULL_CNT  = (LOG_DEPTH+1)'(DEPTH);
  localparam logic [LOG_DEPTH:0]   CNT_ONE   = (LOG_DEPTH+1)'(1);
  localparam logic [LOG_DEPTH-1:0] PTR_ONE   = LOG_DEPTH'(1);

  // Line storage (no reset needed: occupancy gates every read).
  logic [FULL_WIDTH-1:0] data_q [DEPTH];
  logic [7:0]            base_q [DEPTH];
  logic [7:0]            eb_q   [DEPTH];

  logic [DEPTH-1:0]      last_q,   last_d;
  logic [LOG_DEPTH-1:0]  wrline_q, wrline_d;
  logic [LOG_DEPTH-1:0]  rdline_q, rdline_d;
  logic [7:0]            rdptr_q,  rdptr_d;
  logic [LOG_DEPTH:0]    lines_q,  lines_d;
  logic                  drain_q,  drain_d;

  logic [7:0]            in_eb;
  logic                  in_empty;
  logic                  in_rdy;
  logic                  accept;
  logic                  store;
  logic                  out_vld;
  logic                  last_elem;
  logic                  out_lst;
  logic                  xfer;
  logic                  pop;
  logic [LOG_DEPTH-1:0]  rdnext;
  logic [FULL_WIDTH-1:0] head_line;
  logic [WIDTH-1:0]      head_elem;

  // Handshake and window decode.
  always_comb begin
    // Clamp rather than wrap: bounds past the line end just mean "to the end".
    in_eb     = (bus.in_bounds > MAX_EB) ? MAX_EB : bus.in_bounds;
    in_empty  = (bus.in_base >= in_eb);
    in_rdy    = (lines_q != FULL_CNT);
    accept    = bus.in_valid && in_rdy;
    // Empty windows are swallowed: accepted but never occupy a slot.
    store     = accept && !in_empty;
    out_vld   = (lines_q != '0);
    last_elem = ((rdptr_q + 8'd1) == eb_q[rdline_q]);
    out_lst   = out_vld && last_q[rdline_q] && last_elem;
    xfer      = out_vld && bus.out_ready;
    pop       = xfer && last_elem;
    rdnext    = rdline_q + PTR_ONE;
  end

  // Show-ahead element select; element 0 is the MSB chunk of the line.
  always_comb begin
    head_line = data_q[rdline_q];
    head_elem = '0;
    for (int k = 0; k < MAX_ELEMS; k++) begin
      if (rdptr_q == 8'(k)) begin
        head_elem = head_line[FULL_WIDTH-1-k*WIDTH -: WIDTH];
      end
    end
  end

  // Next-state logic.
  always_comb begin
    last_d   = last_q;
    wrline_d = wrline_q;
    rdline_d = rdline_q;
    rdptr_d  = rdptr_q;
    lines_d  = lines_q;
    drain_d  = (xfer && out_lst) || (accept && in_empty && bus.in_last);

    if (store) begin
      wrline_d         = wrline_q + PTR_ONE;
      last_d[wrline_q] = bus.in_last;
    end

    if (pop) begin
      rdline_d = rdnext;
    end

    // Head pointer: advance within the line, or jump straight to the next
    // line's base on the final element so line boundaries cost no bubble.
    // If the incoming line becomes the head this cycle its base is only on
    // the input bus, not yet in base_q.
    if (xfer && !last_elem) begin
      rdptr_d = rdptr_q + 8'd1;
    end else if (store && ((lines_q == '0) || (pop && (lines_q == CNT_ONE)))) begin
      rdptr_d = bus.in_base;
    end else if (pop) begin
      rdptr_d = base_q[rdnext];
    end

    case ({store, pop})
      2'b10:   lines_d = lines_q + CNT_ONE;
      2'b01:   lines_d = lines_q - CNT_ONE;
      default: lines_d = lines_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q   <= '0;
      wrline_q <= '0;
      rdline_q <= '0;
      rdptr_q  <= '0;
      lines_q  <= '0;
      drain_q  <= 1'b0;
    end else begin
      last_q   <= last_d;
      wrline_q <= wrline_d;
      rdline_q <= rdline_d;
      rdptr_q  <= rdptr_d;
      lines_q  <= lines_d;
      drain_q  <= drain_d;
    end
  end

  always_ff @(posedge clk) begin
    if (store) begin
      data_q[wrline_q] <= bus.in_data;
      base_q[wrline_q] <= bus.in_base;
      eb_q[wrline_q]   <= in_eb;
    end
  end

  assign bus.in_ready   = in_rdy;
  assign bus.out_valid  = out_vld;
  assign bus.out_data   = head_elem;
  assign bus.out_last   = out_lst;
  assign bus.drain_done = drain_q;
  assign bus.lines      = lines_q;
endmodule

// File: tb/tb_line_unpack_buffer.sv
// Purpose: self-checking bench for line_unpack_buffer with a queue scoreboard of expected elements.
// Latency: checks first-element timing, back-to-back throughput and drain_done pulse timing.
// Backpressure: exercises full buffer with out_ready low and simultaneous write/pop.
module tb_line_unpack_buffer;
  localparam int FW = 512;
  localparam int W  = 64;
  localparam int LD = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  line_unpack_buffer_if #(.FULL_WIDTH(FW), .WIDTH(W), .LOG_DEPTH(LD)) bus ();

  line_unpack_buffer #(.FULL_WIDTH(FW), .WIDTH(W), .LOG_DEPTH(LD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [63:0] dat;
    logic        last;
  } exp_t;

  exp_t expq[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
    n_chk++;
    if (obs === want) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, want);
  endtask

  function automatic logic [63:0] elem(input logic [7:0] tag, input int k);
    return {48'h0, tag, 8'h10 + 8'(k)};
  endfunction

  function automatic logic [FW-1:0] mk_line(input logic [7:0] tag);
    logic [FW-1:0] l;
    l = '0;
    for (int k = 0; k < FW / W; k++) l[FW-1-k*W -: W] = elem(tag, k);
    return l;
  endfunction

  function automatic int eff_bound(input logic [7:0] bounds);
    return (int'(bounds) > FW / W) ? FW / W : int'(bounds);
  endfunction

  function automatic bit is_empty(input logic [7:0] base, input logic [7:0] bounds);
    return int'(base) >= eff_bound(bounds);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one line; expectations are queued once in_ready is seen, so they
  // follow the accepted order.
  task automatic send(input logic [7:0] tag, input logic [7:0] base,
                      input logic [7:0] bounds, input logic last);
    int eb;
    bit ok;
    eb            = eff_bound(bounds);
    bus.in_valid  = 1'b1;
    bus.in_data   = mk_line(tag);
    bus.in_base   = base;
    bus.in_bounds = bounds;
    bus.in_last   = last;
    ok = 1'b0;
    for (int g = 0; g < 1000 && !ok; g++) begin
      @(negedge clk);
      if (bus.in_ready) ok = 1'b1;
    end
    if (!ok) chk("in_ready_timeout", 64'd0, 64'd1);
    else begin
      for (int k = int'(base); k < eb; k++) begin
        exp_t e;
        e.dat  = elem(tag, k);
        e.last = last && (k == eb - 1);
        expq.push_back(e);
      end
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_empty(input int budget);
    for (int g = 0; g < budget && expq.size() != 0; g++) tick();
    chk("sb_drained", 64'(expq.size()), 64'd0);
  endtask

  // Output monitor: scoreboard pop, drain_done timing, optional gap check.
  int cyc       = 0;
  int prev_cyc  = -1;
  int drain_cnt = 0;
  bit gap_chk   = 1'b0;
  bit drain_pend = 1'b0;

  always @(negedge clk) begin
    bit   nxt;
    exp_t e;
    cyc++;
    nxt = 1'b0;
    if (bus.drain_done) drain_cnt++;
    if (rst) begin
      drain_pend = 1'b0;
    end else begin
      if (drain_pend || bus.drain_done)
        chk("drain_done", 64'(bus.drain_done), 64'(drain_pend));
      if (bus.out_valid && bus.out_ready) begin
        if (expq.size() == 0) chk("unexpected_out", 64'd1, 64'd0);
        else begin
          e = expq.pop_front();
          chk("out_data", bus.out_data, e.dat);
          chk("out_last", 64'(bus.out_last), 64'(e.last));
          nxt = e.last;
        end
        if (gap_chk && prev_cyc >= 0) chk("b2b_gap", 64'(cyc - prev_cyc), 64'd1);
        prev_cyc = cyc;
      end
      if (bus.in_valid && bus.in_ready && bus.in_last && is_empty(bus.in_base, bus.in_bounds))
        nxt = 1'b1;
      drain_pend = nxt;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic single_line(input string pfx);
    bus.out_ready = 1'b1;
    gap_chk  = 1'b1;
    prev_cyc = -1;
    send(8'h00, 8'd0, 8'd8, 1'b1);
    chk({pfx, "_lat_valid"}, 64'(bus.out_valid), 64'd1);
    chk({pfx, "_first_data"}, bus.out_data, 64'h10);
    wait_empty(50);
    tick();
    tick();
    gap_chk = 1'b0;
  endtask

  initial begin
    int d0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_base   = '0;
    bus.in_bounds = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_in_ready",   64'(bus.in_ready),   64'd1);
    chk("rst_out_valid",  64'(bus.out_valid),  64'd0);
    chk("rst_out_last",   64'(bus.out_last),   64'd0);
    chk("rst_drain_done", 64'(bus.drain_done), 64'd0);
    chk("rst_lines",      64'(bus.lines),      64'd0);
    tick();

    // Single line, full window.
    single_line("s1");

    // Window and clamp, back-to-back across lines.
    gap_chk  = 1'b1;
    prev_cyc = -1;
    send(8'h01, 8'd2, 8'd5, 1'b0);
    send(8'h02, 8'd6, 8'd20, 1'b1);
    wait_empty(50);
    tick();
    tick();
    gap_chk = 1'b0;

    // Empty lines are dropped; the last one still ends the stream.
    d0 = drain_cnt;
    send(8'h03, 8'd5, 8'd5, 1'b0);
    chk("empty_lines_a",  64'(bus.lines),     64'd0);
    chk("empty_valid_a",  64'(bus.out_valid), 64'd0);
    send(8'h04, 8'd3, 8'd2, 1'b1);
    chk("empty_lines_b",  64'(bus.lines),     64'd0);
    chk("empty_valid_b",  64'(bus.out_valid), 64'd0);
    tick();
    tick();
    chk("empty_drain_cnt", 64'(drain_cnt - d0), 64'd1);

    // Full buffer with the consumer stalled.
    bus.out_ready = 1'b0;
    for (int i = 0; i < 16; i++) send(8'(16 + i), 8'd0, 8'd8, 1'b0);
    chk("full_lines",    64'(bus.lines),    64'd16);
    chk("full_in_ready", 64'(bus.in_ready), 64'd0);
    fork
      send(8'h40, 8'd0, 8'd8, 1'b1);
      begin
        bus.out_ready = 1'b1;
        repeat (7) tick();
        chk("full_rdy_during_pop", 64'(bus.in_ready), 64'd0);
        tick();
        chk("full_rdy_after_pop", 64'(bus.in_ready), 64'd1);
        chk("full_lines_after_pop", 64'(bus.lines), 64'd15);
        bus.out_ready = 1'b0;
      end
    join
    bus.out_ready = 1'b1;
    wait_empty(400);
    tick();
    tick();

    // Simultaneous write and pop of the only stored line.
    bus.out_ready = 1'b0;
    send(8'h50, 8'd7, 8'd8, 1'b0);
    bus.out_ready = 1'b1;
    send(8'h51, 8'd4, 8'd8, 1'b1);
    chk("simul_lines", 64'(bus.lines),     64'd1);
    chk("simul_valid", 64'(bus.out_valid), 64'd1);
    chk("simul_data",  bus.out_data,       elem(8'h51, 4));
    wait_empty(50);
    tick();
    tick();

    // Reset mid-line with three lines buffered and a handshake in flight.
    bus.out_ready = 1'b0;
    send(8'h60, 8'd0, 8'd8, 1'b0);
    send(8'h61, 8'd0, 8'd8, 1'b0);
    send(8'h62, 8'd0, 8'd8, 1'b0);
    bus.out_ready = 1'b1;
    tick();
    tick();
    tick();
    chk("pre_rst_lines", 64'(bus.lines), 64'd3);
    rst           = 1'b1;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = mk_line(8'h63);
    bus.in_base   = 8'd0;
    bus.in_bounds = 8'd8;
    bus.in_last   = 1'b1;
    tick();
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    expq.delete();
    chk("post_rst_valid",    64'(bus.out_valid), 64'd0);
    chk("post_rst_lines",    64'(bus.lines),     64'd0);
    chk("post_rst_in_ready", 64'(bus.in_ready),  64'd1);
    tick();
    chk("post_rst_still_empty", 64'(bus.out_valid), 64'd0);
    single_line("s6");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
